// File: rtl/pipeline_exfi_skid.sv
// EX->FI pipeline stage with valid/ready handshake and a two-entry skid buffer.
// M drives the outputs and S catches the bundle accepted while FI stalls.
// in_ready is registered, so there is no combinational path from out_ready.
// Optional build macro EXFI_STATS_EN adds the stall_cnt and flush_cnt counters.
module pipeline_exfi_skid #(
  parameter int DATA_W = 16,
  parameter int FLAG_W = 3,
  parameter int PC_W   = 9,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [FLAG_W-1:0] zflags,
  input  logic [PC_W-1:0]   pc,
  input  logic              loads,
  input  logic [OP_W-1:0]   opcode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_out_q,
  output logic [FLAG_W-1:0] zflags_q,
  output logic [PC_W-1:0]   pc_q,
  output logic              loads_q,
  output logic [OP_W-1:0]   opcode_q
`ifdef EXFI_STATS_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [7:0]        flush_cnt
`endif
);

  localparam int BW = DATA_W + FLAG_W + PC_W + 1 + OP_W;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   m_q, m_d;
  logic [BW-1:0]   s_q, s_d;
  logic            rdy_q;
  logic [BW-1:0]   bundle_in;
  logic            accept;
  logic            drain;

  assign bundle_in = {alu_out, zflags, pc, loads, opcode};
  assign accept    = in_valid & rdy_q;
  assign drain     = (state_q != EMPTY) & out_ready;

  // Next-state and storage update; flush overrides accept and drain
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            m_d     = bundle_in;
          end
        end
        ONE: begin
          if (accept && drain) begin
            m_d = bundle_in;
          end else if (accept) begin
            state_d = FULL;
            s_d     = bundle_in;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            state_d = ONE;
            m_d     = s_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State, storage and registered ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      m_q     <= '0;
      s_q     <= '0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
      rdy_q   <= (state_d != FULL);
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = (state_q != EMPTY);
  assign opcode_q  = m_q[OP_W-1:0];
  assign loads_q   = m_q[OP_W] & out_valid;
  assign pc_q      = m_q[OP_W+1 +: PC_W];
  assign zflags_q  = m_q[OP_W+1+PC_W +: FLAG_W];
  assign alu_out_q = m_q[OP_W+1+PC_W+FLAG_W +: DATA_W];

`ifdef EXFI_STATS_EN
  logic [15:0] stall_q;
  logic [7:0]  fcnt_q;

  // Saturating stall and discarding-flush counters; flush does not clear them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      fcnt_q  <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_q != '1)) begin
        stall_q <= stall_q + 16'd1;
      end
      if (flush && (state_q != EMPTY) && (fcnt_q != '1)) begin
        fcnt_q <= fcnt_q + 8'd1;
      end
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = fcnt_q;
`endif

endmodule

// File: tb/tb_pipeline_exfi_skid.sv
// Directed self-checking bench for pipeline_exfi_skid.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_pipeline_exfi_skid;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] alu_out;
  logic [2:0]  zflags;
  logic [8:0]  pc;
  logic        loads;
  logic [2:0]  opcode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] alu_out_q;
  logic [2:0]  zflags_q;
  logic [8:0]  pc_q;
  logic        loads_q;
  logic [2:0]  opcode_q;
`ifdef EXFI_STATS_EN
  logic [15:0] stall_cnt;
  logic [7:0]  flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pipeline_exfi_skid #(.DATA_W(16), .FLAG_W(3), .PC_W(9), .OP_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_out   (alu_out),
    .zflags    (zflags),
    .pc        (pc),
    .loads     (loads),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out_q (alu_out_q),
    .zflags_q  (zflags_q),
    .pc_q      (pc_q),
    .loads_q   (loads_q),
    .opcode_q  (opcode_q)
`ifdef EXFI_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [2:0] z,
                       input logic [8:0] p, input logic l, input logic [2:0] o);
    in_valid = v;
    alu_out  = a;
    zflags   = z;
    pc       = p;
    loads    = l;
    opcode   = o;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 16'h0, 3'b0, 9'd0, 1'b0, 3'd0);
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_alu",       32'(alu_out_q), 32'd0);
    check("rst_loads",     32'(loads_q),   32'd0);
    rst_n = 1'b1;

    // single bundle
    out_ready = 1'b1;
    drive(1'b1, 16'h1234, 3'b001, 9'd5, 1'b1, 3'd2);
    step();
    check("single_valid",  32'(out_valid), 32'd1);
    check("single_alu",    32'(alu_out_q), 32'h1234);
    check("single_flags",  32'(zflags_q),  32'd1);
    check("single_pc",     32'(pc_q),      32'd5);
    check("single_loads",  32'(loads_q),   32'd1);
    check("single_opcode", 32'(opcode_q),  32'd2);
    drive(1'b0, 16'h0, 3'b0, 9'd0, 1'b0, 3'd0);
    step();
    check("single_empty",  32'(out_valid), 32'd0);
    check("single_nold",   32'(loads_q),   32'd0);

    // streaming at full rate
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'(i), 3'(i), 9'(i + 100), 1'b0, 3'(i));
      check("stream_in_ready", 32'(in_ready), 32'd1);
      step();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_alu",   32'(alu_out_q), 32'(i));
      check("stream_pc",    32'(pc_q),      32'(i + 100));
    end
    drive(1'b0, 16'h0, 3'b0, 9'd0, 1'b0, 3'd0);
    step();
    check("stream_drained", 32'(out_valid), 32'd0);

    // back-pressure: A, B accepted, C held by EX
    out_ready = 1'b0;
    drive(1'b1, 16'hA0A0, 3'b010, 9'd10, 1'b1, 3'd1);
    step();
    check("bp_A_valid", 32'(out_valid), 32'd1);
    check("bp_A_alu",   32'(alu_out_q), 32'hA0A0);
    check("bp_A_ready", 32'(in_ready),  32'd1);
    drive(1'b1, 16'hB0B0, 3'b100, 9'd11, 1'b0, 3'd3);
    step();
    check("bp_B_ready", 32'(in_ready),  32'd0);
    check("bp_B_alu",   32'(alu_out_q), 32'hA0A0);
    drive(1'b1, 16'hC0C0, 3'b111, 9'd12, 1'b1, 3'd7);
    for (int i = 0; i < 2; i++) begin
      step();
      check("bp_hold_alu",   32'(alu_out_q), 32'hA0A0);
      check("bp_hold_pc",    32'(pc_q),      32'd10);
      check("bp_hold_ready", 32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    step();
    check("bp_out_B_alu",   32'(alu_out_q), 32'hB0B0);
    check("bp_out_B_loads", 32'(loads_q),   32'd0);
    check("bp_out_B_ready", 32'(in_ready),  32'd1);
    step();
    check("bp_out_C_alu",   32'(alu_out_q), 32'hC0C0);
    check("bp_out_C_op",    32'(opcode_q),  32'd7);
    drive(1'b0, 16'h0, 3'b0, 9'd0, 1'b0, 3'd0);
    step();
    check("bp_drained", 32'(out_valid), 32'd0);

    // flush while FULL with out_ready high
    out_ready = 1'b0;
    drive(1'b1, 16'h1111, 3'b001, 9'd20, 1'b1, 3'd1);
    step();
    drive(1'b1, 16'h2222, 3'b010, 9'd21, 1'b1, 3'd2);
    step();
    check("fl_full_ready", 32'(in_ready), 32'd0);
    drive(1'b0, 16'h0, 3'b0, 9'd0, 1'b0, 3'd0);
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0;
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_loads", 32'(loads_q),   32'd0);
    check("fl_ready", 32'(in_ready),  32'd1);
    step();
    check("fl_after_valid", 32'(out_valid), 32'd0);

    // asynchronous reset while FULL
    out_ready = 1'b0;
    drive(1'b1, 16'h3333, 3'b011, 9'd30, 1'b1, 3'd3);
    step();
    drive(1'b1, 16'h4444, 3'b101, 9'd31, 1'b1, 3'd4);
    step();
    check("ar_full_ready", 32'(in_ready), 32'd0);
    drive(1'b0, 16'h0, 3'b0, 9'd0, 1'b0, 3'd0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_ready", 32'(in_ready),  32'd1);
    check("ar_alu",   32'(alu_out_q), 32'd0);
    check("ar_flags", 32'(zflags_q),  32'd0);
    check("ar_pc",    32'(pc_q),      32'd0);
    check("ar_loads", 32'(loads_q),   32'd0);
    check("ar_op",    32'(opcode_q),  32'd0);
    #1 rst_n = 1'b1;

`ifdef EXFI_STATS_EN
    check("st_rst_stall", 32'(stall_cnt), 32'd0);
    check("st_rst_flush", 32'(flush_cnt), 32'd0);
    out_ready = 1'b0;
    drive(1'b1, 16'h5555, 3'b001, 9'd40, 1'b1, 3'd5);
    step();
    drive(1'b0, 16'h0, 3'b0, 9'd0, 1'b0, 3'd0);
    repeat (5) step();
    check("st_stall5", 32'(stall_cnt), 32'd5);
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0; out_ready = 1'b0;
    check("st_stall_keep", 32'(stall_cnt), 32'd5);
    check("st_flush1",     32'(flush_cnt), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("st_flush_empty", 32'(flush_cnt), 32'd1);
    drive(1'b1, 16'h6666, 3'b001, 9'd41, 1'b0, 3'd6);
    step();
    drive(1'b0, 16'h0, 3'b0, 9'd0, 1'b0, 3'd0);
    repeat (70000) step();
    check("st_stall_sat", 32'(stall_cnt), 32'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_exfi_skid.md
Name: pipeline_exfi_skid

Overview:
- Parametrised EX->FI pipeline stage. It carries the ALU result, Z flags, PC, the loads bit and the opcode from execute to finish.
- Adds a valid/ready handshake, a two-entry skid buffer, synchronous flush and asynchronous active-low reset.
- Lets FI back-pressure EX without a combinational ready path.
- Sits between the execute datapath and the FI/writeback stage.

Parameters:
DATA_W, 16, width of ALU result
FLAG_W, 3, width of Z/N/V flag vector
PC_W, 9, width of program counter
OP_W, 3, width of forwarded opcode field

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of all held entries
in_valid  in  1  EX presents a valid bundle
in_ready  out  1  stage can accept; registered (depends on state only)
alu_out  in  DATA_W  ALU result
zflags  in  FLAG_W  status flags
pc  in  PC_W  PC of the instruction
loads  in  1  write-back load enable
opcode  in  OP_W  opcode
out_valid  out  1  bundle valid toward FI
out_ready  in  1  FI accepts bundle
alu_out_q  out  DATA_W  registered ALU result
zflags_q  out  FLAG_W  registered flags
pc_q  out  PC_W  registered PC
loads_q  out  1  registered loads; forced 0 when out_valid=0
opcode_q  out  OP_W  registered opcode

Behaviour:
- Bundle = {alu_out, zflags, pc, loads, opcode}, stored as one word.
- Storage: main register M (drives outputs) and skid register S.
- Reset (rst_n=0, asynchronous): state EMPTY; M and S zero; out_valid=0; all *_q outputs 0; in_ready=1.
- States:
  - EMPTY: M and S invalid; in_ready=1.
  - ONE: M valid; in_ready=1.
  - FULL: M and S valid; in_ready=0.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- EMPTY + accept -> ONE; M <= input. Latency: accepted at edge N, visible on outputs after edge N.
- ONE + accept + drain -> ONE; M <= input.
- ONE + accept, no drain -> FULL; S <= input; M holds.
- ONE + drain, no accept -> EMPTY.
- FULL + drain -> ONE; M <= S. No accept is possible because in_ready=0.
- FULL, no drain -> hold.
- While out_valid=1 and out_ready=0, the *_q outputs are stable (no change).
- No bundle is dropped or duplicated; output order equals accept order.
- loads_q = M.loads & out_valid. An invalid slot never triggers a write-back.
- flush=1 at an edge:
  - Next state EMPTY; out_valid=0; in_ready=1.
  - Any bundle accepted or drained in that same cycle is discarded.
  - *_q data fields may hold stale values; loads_q=0.
- flush has priority over accept and drain.
- Reset asserted mid-operation: immediate return to EMPTY and zeroed outputs, independent of clk.
- No internal arithmetic. Widths pass through unchanged; no truncation.

Optional Feature:
- Macro: EXFI_STATS_EN.
- Defined:
  - Adds output stall_cnt [15:0]: counts cycles with out_valid=1 & out_ready=0.
  - Adds output flush_cnt [7:0]: counts flush edges that discarded at least one valid entry.
  - Both counters saturate at all-ones, reset to 0 on rst_n=0, and are not cleared by flush.
- Undefined: these ports and counters do not exist. Datapath behaviour is identical in both cases.

Test Plan:
- Reset then a single bundle {alu_out=16'h1234, zflags=3'b001, pc=9'd5, loads=1, opcode=3'd2} with out_ready=1 -> out_valid=1 one edge later, outputs match, next cycle out_valid=0.
- Stream 8 bundles (alu_out=0..7) with out_ready=1 every cycle -> in_ready constantly 1, 8 outputs in order, one per cycle.
- Hold out_ready=0 and offer 3 bundles (A, B, C):
  - A and B accepted; in_ready=0 after B; C held by EX.
  - Outputs stay at A while stalled.
  - Raise out_ready -> A, B, C emerge in order.
- FULL state with flush=1 and out_ready=1 in the same cycle -> next cycle out_valid=0, loads_q=0, in_ready=1; neither A nor B appears at the output.
- Assert rst_n=0 between clock edges while in FULL -> out_valid, in_ready and *_q update asynchronously to 0, 1 and 0 respectively.
- With EXFI_STATS_EN: stall 5 cycles, then flush with 1 entry held -> stall_cnt=5, flush_cnt=1. Force 70000 stall cycles -> stall_cnt=16'hFFFF.
